branch_predictor: RTL and testbench
===================================

# branch_predictor

Direct-mapped branch target buffer with 2-bit saturating direction counters for the 5-stage RISC-V pipeline. It is looked up combinationally by the IF stage with the current PC and supplies a predicted next PC, replacing the current scheme of always fetching pc+4 and flushing on every taken jump. The EX stage updates it when a branch or jump resolves, and it counts mispredictions for performance monitoring.

## Interface
Parameters:
- ENTRIES, 64, number of BTB entries; power of 2, at least 4; IDX_W = log2(ENTRIES).
- TAG_W, 8, tag bits taken from the PC above the index; IDX_W+2+TAG_W ≤ 32.
- GHR_W, 6, global history length; used only with BP_GSHARE_EN; GHR_W ≤ IDX_W.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- IF_pc  in  32  fetch PC to look up.
- pred_taken  out  1  predicted taken.
- pred_target  out  32  predicted next PC.
- pred_hit  out  1  BTB tag hit for IF_pc.
- pred_ghr  out  GHR_W  history snapshot to carry down the pipe; 0 without the macro.
- upd_valid  in  1  EX resolved a control-transfer instruction this cycle.
- upd_pc  in  32  PC of the resolved instruction.
- upd_taken  in  1  actual outcome.
- upd_target  in  32  actual target address.
- upd_is_cond  in  1  1 = conditional branch, 0 = jal/jalr.
- upd_mispred  in  1  pipeline flushed for this instruction.
- upd_ghr  in  GHR_W  pred_ghr captured at prediction time; ignored without the macro.
- mispred_cnt  out  32  count of mispredictions.

## Operation
- Index and tag:
  - idx = pc[IDX_W+1:2].
  - tag = pc[IDX_W+1+TAG_W:IDX_W+2].
  - pc[1:0] are ignored.
- Entry fields: valid, tag, target[31:0], is_cond, ctr[1:0].
- Lookup (combinational):
  - pred_hit = valid && tag match.
  - pred_taken = pred_hit && (!is_cond || ctr[1]).
  - pred_target = pred_taken ? target : IF_pc+4, with 32-bit wrap (0xFFFFFFFC → 0x00000000).
- Update when upd_valid=1, for the entry at idx(upd_pc):
  - **Hit:**
    - ctr saturates upward on taken and downward on not-taken (3 stays 3, 0 stays 0).
    - If taken, target ← upd_target.
    - is_cond ← upd_is_cond.
  - **Miss, taken:**
    - The entry is allocated, overwriting the direct-mapped slot.
    - valid=1, tag, target and is_cond are written; ctr=2'b10.
  - **Miss, not-taken:** no change.
- Unconditional entries always predict taken; their ctr is still updated but has no effect.
- mispred_cnt increments when upd_valid && upd_mispred and wraps 0xFFFFFFFF → 0. upd_mispred without upd_valid is ignored.
- Reset:
  - Clears every valid bit, every ctr to 2'b01, mispred_cnt to 0 and the GHR to 0.
  - Reset wins over a simultaneous upd_valid.
  - Reset in the middle of a run discards all training.

## Timing
- Prediction latency is 0 cycles: outputs are a combinational function of IF_pc and the current state.
- An update is written at the rising edge and is visible to a lookup from the next cycle.
- Lookup and update to the same index in the same cycle: the lookup returns the pre-update contents. There is no bypass.
- Output values while in reset and in the cycle after: pred_hit=0, pred_taken=0, pred_target=IF_pc+4, pred_ghr=0, mispred_cnt=0.
- No handshake: one update is accepted per cycle with no backpressure.

## Configuration
- BP_GSHARE_EN defined:
  - Direction comes from a separate ENTRIES-deep PHT of 2-bit counters, reset to 2'b01.
  - The PHT is read at idx(IF_pc) XOR zero-extended GHR.
  - The PHT is updated at idx(upd_pc) XOR zero-extended upd_ghr.
  - pred_ghr = GHR.
  - On each upd_valid && upd_is_cond, GHR ← {GHR[GHR_W-2:0], upd_taken}.
  - The per-entry ctr field is absent.
- BP_GSHARE_EN undefined:
  - Direction comes from the per-entry ctr.
  - pred_ghr is tied to 0, upd_ghr is unused, and there is no GHR.

## Test plan
- Cold start: reset, then IF_pc=0x100 → pred_hit=0, pred_taken=0, pred_target=0x104, mispred_cnt=0.
- Allocate: upd_pc=0x100, taken, target 0x40, is_cond=1, then IF_pc=0x100 the next cycle → hit, taken, target 0x40. Two not-taken updates → pred_taken=0, pred_target=0x104. A third not-taken update keeps ctr at 0. Two taken updates are needed before pred_taken=1 again.
- Alias (ENTRIES=64): allocate 0x100 taken, then allocate 0x200 taken (same idx, different tag) → IF_pc=0x100 misses and IF_pc=0x200 hits.
- Unconditional: upd_pc=0x300, is_cond=0, taken, target 0x80, then 4 not-taken updates → IF_pc=0x300 still predicts taken with target 0x80.
- Same-cycle update: IF_pc=upd_pc=0x400 on allocation → pred_hit=0 that cycle and 1 the next.
- Counter and reset: 3 updates with upd_mispred=1 and one with upd_mispred=1 but upd_valid=0 → mispred_cnt=3. Assert reset together with upd_valid → mispred_cnt=0 and all lookups miss.

Source files
------------

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating direction counters, combinational lookup and misprediction counter.
// Optional gshare direction predictor enabled by defining BP_GSHARE_EN.
module branch_predictor #(
    parameter int ENTRIES = 64,
    parameter int TAG_W   = 8,
    parameter int GHR_W   = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      IF_pc,
    output logic             pred_taken,
    output logic [31:0]      pred_target,
    output logic             pred_hit,
    output logic [GHR_W-1:0] pred_ghr,
    input  logic             upd_valid,
    input  logic [31:0]      upd_pc,
    input  logic             upd_taken,
    input  logic [31:0]      upd_target,
    input  logic             upd_is_cond,
    input  logic             upd_mispred,
    input  logic [GHR_W-1:0] upd_ghr,
    output logic [31:0]      mispred_cnt
);
    localparam int IDX_W = $clog2(ENTRIES);

    function automatic logic [1:0] sat_ctr(input logic [1:0] ctr, input logic taken);
        logic [1:0] res;
        res = ctr;
        if (taken) begin
            if (ctr != 2'b11) res = ctr + 2'b01;
            else              res = ctr;
        end else begin
            if (ctr != 2'b00) res = ctr - 2'b01;
            else              res = ctr;
        end
        return res;
    endfunction

    logic              valid_r   [ENTRIES];
    logic [TAG_W-1:0]  tag_r     [ENTRIES];
    logic [31:0]       target_r  [ENTRIES];
    logic              is_cond_r [ENTRIES];
    logic [31:0]       mispred_cnt_r;

    logic [IDX_W-1:0]  if_idx_s;
    logic [TAG_W-1:0]  if_tag_s;
    logic [IDX_W-1:0]  upd_idx_s;
    logic [TAG_W-1:0]  upd_tag_s;
    logic              upd_hit_s;
    logic              dir_s;
    logic              hit_s;
    logic              taken_s;
    logic              unused_s;

    assign if_idx_s  = IF_pc[IDX_W+1:2];
    assign if_tag_s  = IF_pc[IDX_W+1+TAG_W:IDX_W+2];
    assign upd_idx_s = upd_pc[IDX_W+1:2];
    assign upd_tag_s = upd_pc[IDX_W+1+TAG_W:IDX_W+2];
    assign upd_hit_s = valid_r[upd_idx_s] && (tag_r[upd_idx_s] == upd_tag_s);
    assign unused_s  = ^{IF_pc, upd_pc, upd_ghr};

`ifdef BP_GSHARE_EN
    logic [1:0]        pht_r [ENTRIES];
    logic [GHR_W-1:0]  ghr_r;
    logic [IDX_W-1:0]  pht_rd_idx_s;
    logic [IDX_W-1:0]  pht_wr_idx_s;

    assign pht_rd_idx_s = if_idx_s ^ IDX_W'(ghr_r);
    assign pht_wr_idx_s = upd_idx_s ^ IDX_W'(upd_ghr);
    assign dir_s        = pht_r[pht_rd_idx_s][1];
    assign pred_ghr     = reset ? {GHR_W{1'b0}} : ghr_r;

    // Pattern history table and global history register training.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) pht_r[i] <= 2'b01;
            ghr_r <= {GHR_W{1'b0}};
        end else if (upd_valid && upd_is_cond) begin
            pht_r[pht_wr_idx_s] <= sat_ctr(pht_r[pht_wr_idx_s], upd_taken);
            ghr_r               <= {ghr_r[GHR_W-2:0], upd_taken};
        end
    end
`else
    logic [1:0]        ctr_r [ENTRIES];

    assign dir_s    = ctr_r[if_idx_s][1];
    assign pred_ghr = {GHR_W{1'b0}};

    // Per-entry direction counters: trained on hit, seeded weakly-taken on allocation.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) ctr_r[i] <= 2'b01;
        end else if (upd_valid && upd_hit_s) begin
            ctr_r[upd_idx_s] <= sat_ctr(ctr_r[upd_idx_s], upd_taken);
        end else if (upd_valid && upd_taken) begin
            ctr_r[upd_idx_s] <= 2'b10;
        end
    end
`endif

    // Lookup; reset forces a miss so stale training never leaks out while reset is held.
    always_comb begin
        hit_s   = 1'b0;
        taken_s = 1'b0;
        if (!reset) begin
            hit_s = valid_r[if_idx_s] && (tag_r[if_idx_s] == if_tag_s);
        end else begin
            hit_s = 1'b0;
        end
        taken_s = hit_s && (!is_cond_r[if_idx_s] || dir_s);
    end

    assign pred_hit    = hit_s;
    assign pred_taken  = taken_s;
    assign pred_target = taken_s ? target_r[if_idx_s] : (IF_pc + 32'd4);
    assign mispred_cnt = reset ? 32'd0 : mispred_cnt_r;

    // Valid bits and the misprediction counter; reset beats a simultaneous update.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) valid_r[i] <= 1'b0;
            mispred_cnt_r <= 32'd0;
        end else begin
            if (upd_valid && !upd_hit_s && upd_taken) valid_r[upd_idx_s] <= 1'b1;
            if (upd_valid && upd_mispred) mispred_cnt_r <= mispred_cnt_r + 32'd1;
        end
    end

    // Entry payload; only meaningful under a set valid bit, so it needs no reset.
    always_ff @(posedge clk) begin
        if (!reset && upd_valid) begin
            if (upd_hit_s) begin
                if (upd_taken) target_r[upd_idx_s] <= upd_target;
                is_cond_r[upd_idx_s] <= upd_is_cond;
            end else if (upd_taken) begin
                tag_r[upd_idx_s]     <= upd_tag_s;
                target_r[upd_idx_s]  <= upd_target;
                is_cond_r[upd_idx_s] <= upd_is_cond;
            end
        end
    end
endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (default build, ENTRIES=64, TAG_W=8).
module tb_branch_predictor;
    logic        clk;
    logic        reset;
    logic [31:0] IF_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        pred_hit;
    logic [5:0]  pred_ghr;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_is_cond;
    logic        upd_mispred;
    logic [5:0]  upd_ghr;
    logic [31:0] mispred_cnt;

    int total = 0;
    int bad   = 0;

    branch_predictor dut (
        .clk(clk), .reset(reset), .IF_pc(IF_pc),
        .pred_taken(pred_taken), .pred_target(pred_target), .pred_hit(pred_hit),
        .pred_ghr(pred_ghr), .upd_valid(upd_valid), .upd_pc(upd_pc),
        .upd_taken(upd_taken), .upd_target(upd_target), .upd_is_cond(upd_is_cond),
        .upd_mispred(upd_mispred), .upd_ghr(upd_ghr), .mispred_cnt(mispred_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                       input logic is_cond, input logic mis);
        upd_pc = pc; upd_taken = taken; upd_target = tgt;
        upd_is_cond = is_cond; upd_mispred = mis; upd_valid = 1'b1;
        tick();
        upd_valid = 1'b0; upd_mispred = 1'b0;
    endtask

    task automatic look(input string tag, input logic [31:0] pc, input logic hit,
                        input logic taken, input logic [31:0] tgt);
        IF_pc = pc;
        #1;
        check_eq({tag, ".hit"}, {31'd0, pred_hit}, {31'd0, hit});
        check_eq({tag, ".taken"}, {31'd0, pred_taken}, {31'd0, taken});
        check_eq({tag, ".target"}, pred_target, tgt);
    endtask

    initial begin
        reset = 1'b1; IF_pc = 32'h100; upd_valid = 1'b0; upd_pc = 32'd0;
        upd_taken = 1'b0; upd_target = 32'd0; upd_is_cond = 1'b0;
        upd_mispred = 1'b0; upd_ghr = 6'd0;
        tick(); tick();
        look("in_reset", 32'h100, 1'b0, 1'b0, 32'h104);
        check_eq("in_reset.ghr", {26'd0, pred_ghr}, 32'd0);
        reset = 1'b0;
        look("cold", 32'h100, 1'b0, 1'b0, 32'h104);
        check_eq("cold.cnt", mispred_cnt, 32'd0);

        // Allocate, then walk the counter down and back up.
        upd(32'h100, 1'b1, 32'h40, 1'b1, 1'b0);
        look("alloc", 32'h100, 1'b1, 1'b1, 32'h40);
        upd(32'h100, 1'b0, 32'h0, 1'b1, 1'b0);
        look("nt1", 32'h100, 1'b1, 1'b0, 32'h104);
        upd(32'h100, 1'b0, 32'h0, 1'b1, 1'b0);
        look("nt2", 32'h100, 1'b1, 1'b0, 32'h104);
        upd(32'h100, 1'b0, 32'h0, 1'b1, 1'b0);
        upd(32'h100, 1'b1, 32'h48, 1'b1, 1'b0);
        look("t1_after_sat0", 32'h100, 1'b1, 1'b0, 32'h104);
        upd(32'h100, 1'b1, 32'h44, 1'b1, 1'b0);
        look("t2", 32'h100, 1'b1, 1'b1, 32'h44);

        // Aliasing on idx 0 and a not-taken miss that must not allocate.
        upd(32'h200, 1'b1, 32'h60, 1'b1, 1'b0);
        look("alias_old", 32'h100, 1'b0, 1'b0, 32'h104);
        look("alias_new", 32'h200, 1'b1, 1'b1, 32'h60);
        upd(32'h500, 1'b0, 32'h70, 1'b1, 1'b0);
        look("nt_miss_keep", 32'h200, 1'b1, 1'b1, 32'h60);
        look("nt_miss_none", 32'h500, 1'b0, 1'b0, 32'h504);

        // Unconditional entry ignores its counter.
        upd(32'h300, 1'b1, 32'h80, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) upd(32'h300, 1'b0, 32'h0, 1'b0, 1'b0);
        look("uncond", 32'h300, 1'b1, 1'b1, 32'h80);

        // Same-cycle lookup and allocation: no bypass.
        IF_pc = 32'h400; upd_pc = 32'h400; upd_taken = 1'b1; upd_target = 32'h90;
        upd_is_cond = 1'b1; upd_valid = 1'b1;
        #1;
        check_eq("same_cycle.hit", {31'd0, pred_hit}, 32'd0);
        tick();
        upd_valid = 1'b0;
        look("next_cycle", 32'h400, 1'b1, 1'b1, 32'h90);

        // PC+4 wrap on a miss at the top of the address space.
        look("wrap", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0000_0000);

        // Misprediction counter; upd_mispred alone is ignored.
        for (int i = 0; i < 3; i++) upd(32'h600, 1'b0, 32'h0, 1'b1, 1'b1);
        upd_mispred = 1'b1;
        tick();
        upd_mispred = 1'b0;
        check_eq("cnt", mispred_cnt, 32'd3);
        look("cnt_no_side_effect", 32'h400, 1'b1, 1'b1, 32'h90);

        // Reset together with an update discards everything.
        reset = 1'b1; upd_pc = 32'h700; upd_taken = 1'b1; upd_target = 32'hA0;
        upd_is_cond = 1'b0; upd_mispred = 1'b1; upd_valid = 1'b1;
        look("reset_held", 32'h400, 1'b0, 1'b0, 32'h404);
        check_eq("reset_held.cnt", mispred_cnt, 32'd0);
        tick();
        reset = 1'b0; upd_valid = 1'b0; upd_mispred = 1'b0;
        look("post_rst_400", 32'h400, 1'b0, 1'b0, 32'h404);
        look("post_rst_700", 32'h700, 1'b0, 1'b0, 32'h704);
        check_eq("post_rst.cnt", mispred_cnt, 32'd0);
        tick();
        check_eq("post_rst2.cnt", mispred_cnt, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
